// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: Funct3 codes, FSM encoding,
// base byte-enable patterns and the Funct3 legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Stores only have signed-size encodings; loads also accept BU/HU.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!is_store) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(
  parameter int DATA_LENGTH = 32,
  parameter int ADDR_LENGTH = 32
);
  logic                   MemReq;
  logic                   MemWE;
  logic [ADDR_LENGTH-1:0] MemAddr;
  logic [3:0]             MemBE;
  logic [DATA_LENGTH-1:0] MemWData;
  logic                   MemAck;
  logic [DATA_LENGTH-1:0] MemRData;

  modport master (
    output MemReq, MemWE, MemAddr, MemBE, MemWData,
    input  MemAck, MemRData
  );

  modport slave (
    input  MemReq, MemWE, MemAddr, MemBE, MemWData,
    output MemAck, MemRData
  );
endinterface

// File: rtl/load_store_align.sv
// Combinational byte-lane steering: builds store enables/data from the live
// request and extracts/extends load data from the returned word.
module load_store_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_offset,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] rdata,
  output logic [31:0] load_word
);

  logic [31:0] shifted;

  // Store side: lane-replicate the data so any enabled lane sees the right byte.
  always_comb begin
    be    = BE_WORD;
    wdata = store_data;
    case (st_funct3[1:0])
      2'b00: begin
        be    = BE_BYTE << st_offset;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = BE_HALF << st_offset;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = BE_WORD;
        wdata = store_data;
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then size and extend.
  always_comb begin
    shifted = rdata >> {ld_offset, 3'b000};
    case (ld_funct3)
      F3_B:    load_word = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_word = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_word = {24'd0, shifted[7:0]};
      F3_HU:   load_word = {16'd0, shifted[15:0]};
      default: load_word = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: IDLE/BUSY/DONE handshake to data memory,
// combinational stall to freeze the core, one-cycle fault on bad requests.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_LENGTH = 32,
  parameter int ADDR_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MemRead,
  input  logic                   MemWrite,
  input  logic [2:0]             Funct3,
  input  logic [ADDR_LENGTH-1:0] Address,
  input  logic [DATA_LENGTH-1:0] StoreData,
  output logic [DATA_LENGTH-1:0] LoadData,
  output logic                   Stall,
  output logic                   Fault,
  load_store_unit_if.master      mem
);

  logic [1:0]  state;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        op;
  logic        bad;
  logic        misalign;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] load_word;

  load_store_align u_align (
    .st_funct3  (Funct3),
    .st_offset  (Address[1:0]),
    .store_data (StoreData),
    .be         (be),
    .wdata      (wdata),
    .ld_funct3  (f3_q),
    .ld_offset  (off_q),
    .rdata      (mem.MemRData),
    .load_word  (load_word)
  );

  // Request decode: an op is rejected if misaligned, illegal size, or both read and write.
  always_comb begin
    op       = MemRead | MemWrite;
    misalign = ((Funct3[1:0] == 2'b01) & Address[0]) |
               ((Funct3[1:0] == 2'b10) & (Address[1:0] != 2'b00));
    bad      = misalign | ~f3_legal(Funct3, MemWrite) | (MemRead & MemWrite);
    Fault    = ~rst & (state == ST_IDLE) & op & bad;
    Stall    = ~rst & (((state == ST_IDLE) & op & ~bad) | (state == ST_BUSY));
  end

  // FSM and registered memory-port/result state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      LoadData     <= '0;
      mem.MemReq   <= 1'b0;
      mem.MemWE    <= 1'b0;
      mem.MemAddr  <= '0;
      mem.MemBE    <= '0;
      mem.MemWData <= '0;
      off_q        <= '0;
      f3_q         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op && !bad) begin
            mem.MemReq   <= 1'b1;
            mem.MemWE    <= MemWrite;
            mem.MemAddr  <= {Address[ADDR_LENGTH-1:2], 2'b00};
            mem.MemBE    <= be;
            mem.MemWData <= wdata;
            off_q        <= Address[1:0];
            f3_q         <= Funct3;
            state        <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem.MemAck) begin
            mem.MemReq <= 1'b0;
            if (!mem.MemWE) begin
              LoadData <= load_word;
            end
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
